// File: rtl/op_dispatch_controller.sv
// Operation dispatch controller: collects operand ids/scalar for a confirmed matrix op and issues one calc_start.
// Optional watchdog in WAIT enabled by defining OP_DISPATCH_TIMEOUT_EN.
package matrix_op_selector_pkg;
    typedef enum logic [2:0] {
        OP_SINGLE = 3'd0,
        OP_DOUBLE = 3'd1,
        OP_SCALAR = 3'd2
    } op_mode_t;

    typedef enum logic [2:0] {
        CALC_ADD        = 3'd0,
        CALC_MUL        = 3'd1,
        CALC_TRANSPOSE  = 3'd2,
        CALC_SCALAR_MUL = 3'd3
    } calc_type_t;

    // True when the mode is known and the calc type is legal for it.
    function automatic logic cmd_ok(logic [2:0] mode, logic [2:0] ctype);
        case (mode)
            OP_SINGLE: return ctype == CALC_TRANSPOSE;
            OP_DOUBLE: return (ctype == CALC_ADD) || (ctype == CALC_MUL);
            OP_SCALAR: return ctype == CALC_SCALAR_MUL;
            default:   return 1'b0;
        endcase
    endfunction
endpackage

module op_dispatch_controller
    import matrix_op_selector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ID_W           = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            confirm,
    input  logic [2:0]      op_mode,
    input  logic [2:0]      calc_type,
    input  logic            operand_valid,
    input  logic [ID_W-1:0] operand_id,
    output logic            operand_ready,
    input  logic            scalar_valid,
    input  logic [31:0]     scalar_value,
    output logic            scalar_ready,
    output logic            calc_start,
    output logic [2:0]      calc_type_o,
    output logic [ID_W-1:0] op_a_id,
    output logic [ID_W-1:0] op_b_id,
    output logic [31:0]     scalar_o,
    input  logic            calc_done,
    input  logic            calc_err,
    output logic            busy,
    output logic            done,
    output logic            error
);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_S, START, WAIT, FIN} state_t;

    state_t     state;
    logic [2:0] op_mode_q;

`ifdef OP_DISPATCH_TIMEOUT_EN
    logic [31:0] wd_cnt;
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_mode_q     <= 3'd0;
            operand_ready <= 1'b0;
            scalar_ready  <= 1'b0;
            calc_start    <= 1'b0;
            calc_type_o   <= 3'd0;
            op_a_id       <= '0;
            op_b_id       <= '0;
            scalar_o      <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef OP_DISPATCH_TIMEOUT_EN
            wd_cnt        <= 32'd0;
`endif
        end else begin
            // NOTE: calc_start defaults low every cycle, so it is only ever a one-cycle pulse.
            calc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (confirm) begin
                        op_mode_q     <= op_mode;
                        calc_type_o   <= calc_type;
                        op_a_id       <= '0;
                        op_b_id       <= '0;
                        scalar_o      <= 32'd0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        // Illegal commands never offer operand_ready, so no stray handshake.
                        operand_ready <= cmd_ok(op_mode, calc_type);
                        state         <= GET_A;
                    end
                end
                GET_A: begin
                    if (!cmd_ok(op_mode_q, calc_type_o)) begin
                        operand_ready <= 1'b0;
                        error         <= 1'b1;
                        state         <= FIN;
                    end else if (operand_valid && operand_ready) begin
                        op_a_id <= operand_id;
                        case (op_mode_q)
                            OP_DOUBLE: state <= GET_B;
                            OP_SCALAR: begin
                                operand_ready <= 1'b0;
                                scalar_ready  <= 1'b1;
                                state         <= GET_S;
                            end
                            default: begin
                                operand_ready <= 1'b0;
                                calc_start    <= 1'b1;
                                state         <= START;
                            end
                        endcase
                    end
                end
                GET_B: begin
                    if (operand_valid && operand_ready) begin
                        op_b_id       <= operand_id;
                        operand_ready <= 1'b0;
                        calc_start    <= 1'b1;
                        state         <= START;
                    end
                end
                GET_S: begin
                    if (scalar_valid && scalar_ready) begin
                        scalar_o     <= scalar_value;
                        scalar_ready <= 1'b0;
                        calc_start   <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    // calc_done during this cycle is deliberately not looked at.
                    state <= WAIT;
`ifdef OP_DISPATCH_TIMEOUT_EN
                    wd_cnt <= 32'd0;
`endif
                end
                WAIT: begin
                    if (calc_done) begin
                        done  <= !calc_err;
                        error <= calc_err;
                        state <= FIN;
`ifdef OP_DISPATCH_TIMEOUT_EN
                    end else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        done  <= 1'b0;
                        error <= 1'b1;
                        state <= FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
`endif
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_dispatch_controller.sv
// Directed self-checking bench for op_dispatch_controller; watchdog step depends on OP_DISPATCH_TIMEOUT_EN.
module tb_op_dispatch_controller;
    import matrix_op_selector_pkg::*;

    localparam int ID_W = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            confirm;
    logic [2:0]      op_mode;
    logic [2:0]      calc_type;
    logic            operand_valid;
    logic [ID_W-1:0] operand_id;
    logic            operand_ready;
    logic            scalar_valid;
    logic [31:0]     scalar_value;
    logic            scalar_ready;
    logic            calc_start;
    logic [2:0]      calc_type_o;
    logic [ID_W-1:0] op_a_id;
    logic [ID_W-1:0] op_b_id;
    logic [31:0]     scalar_o;
    logic            calc_done;
    logic            calc_err;
    logic            busy;
    logic            done;
    logic            error;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    op_dispatch_controller #(.TIMEOUT_CYCLES(16), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .confirm(confirm), .op_mode(op_mode), .calc_type(calc_type),
        .operand_valid(operand_valid), .operand_id(operand_id), .operand_ready(operand_ready),
        .scalar_valid(scalar_valid), .scalar_value(scalar_value), .scalar_ready(scalar_ready),
        .calc_start(calc_start), .calc_type_o(calc_type_o), .op_a_id(op_a_id), .op_b_id(op_b_id),
        .scalar_o(scalar_o), .calc_done(calc_done), .calc_err(calc_err),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (calc_start) n_starts++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".calc_start"},    32'(calc_start),    32'd0);
        check({tag, ".busy"},          32'(busy),          32'd0);
        check({tag, ".done"},          32'(done),          32'd0);
        check({tag, ".error"},         32'(error),         32'd0);
        check({tag, ".operand_ready"}, 32'(operand_ready), 32'd0);
        check({tag, ".scalar_ready"},  32'(scalar_ready),  32'd0);
        check({tag, ".calc_type_o"},   32'(calc_type_o),   32'd0);
        check({tag, ".op_a_id"},       32'(op_a_id),       32'd0);
        check({tag, ".op_b_id"},       32'(op_b_id),       32'd0);
        check({tag, ".scalar_o"},      scalar_o,           32'd0);
    endtask

    initial begin
        rst_n = 1'b0; confirm = 1'b0; op_mode = 3'd0; calc_type = 3'd0;
        operand_valid = 1'b0; operand_id = '0; scalar_valid = 1'b0; scalar_value = 32'd0;
        calc_done = 1'b0; calc_err = 1'b0;
        #1;
        check_all_zero("reset");
        tick(2);

        // Single transpose; confirm on the first edge after reset release.
        rst_n = 1'b1;
        op_mode = OP_SINGLE; calc_type = CALC_TRANSPOSE; confirm = 1'b1;
        operand_valid = 1'b1; operand_id = 3'd5;
        tick(1);
        confirm = 1'b0;
        check("single.busy_get_a", 32'(busy), 32'd1);
        check("single.no_start_c1", 32'(calc_start), 32'd0);
        tick(1);
        check("single.start_c2", 32'(calc_start), 32'd1);
        check("single.op_a", 32'(op_a_id), 32'd5);
        check("single.op_b", 32'(op_b_id), 32'd0);
        operand_valid = 1'b0;
        tick(1);
        check("single.start_one_cycle", 32'(calc_start), 32'd0);
        tick(9);
        calc_done = 1'b1; calc_err = 1'b0;
        tick(1);
        calc_done = 1'b0;
        check("single.done", 32'(done), 32'd1);
        check("single.error", 32'(error), 32'd0);
        check("single.busy_fin", 32'(busy), 32'd1);
        tick(1);
        check("single.busy_idle", 32'(busy), 32'd0);
        check("single.done_hold", 32'(done), 32'd1);
        check("single.starts", 32'(n_starts), 32'd1);

        // Double multiply with gaps between operand offers.
        op_mode = OP_DOUBLE; calc_type = CALC_MUL; confirm = 1'b1;
        tick(1);
        confirm = 1'b0;
        check("double.done_cleared", 32'(done), 32'd0);
        tick(3);
        check("double.ready_a", 32'(operand_ready), 32'd1);
        operand_valid = 1'b1; operand_id = 3'd1;
        tick(1);
        operand_valid = 1'b0;
        check("double.op_a", 32'(op_a_id), 32'd1);
        check("double.no_start_yet", 32'(calc_start), 32'd0);
        tick(3);
        check("double.ready_b", 32'(operand_ready), 32'd1);
        check("double.no_scalar_ready", 32'(scalar_ready), 32'd0);
        operand_valid = 1'b1; operand_id = 3'd2;
        tick(1);
        operand_valid = 1'b0;
        check("double.start", 32'(calc_start), 32'd1);
        check("double.op_b", 32'(op_b_id), 32'd2);
        check("double.calc_type", 32'(calc_type_o), 32'(CALC_MUL));
        check("double.ready_low", 32'(operand_ready), 32'd0);
        tick(1);
        calc_done = 1'b1;
        tick(1);
        calc_done = 1'b0;
        check("double.done", 32'(done), 32'd1);
        tick(1);
        check("double.starts", 32'(n_starts), 32'd2);

        // Scalar multiply, calc_done held through START must be ignored, then error.
        op_mode = OP_SCALAR; calc_type = CALC_SCALAR_MUL; confirm = 1'b1;
        operand_valid = 1'b1; operand_id = 3'd4;
        tick(1);
        confirm = 1'b0;
        tick(1);
        operand_valid = 1'b0;
        check("scalar.op_a", 32'(op_a_id), 32'd4);
        check("scalar.scalar_ready", 32'(scalar_ready), 32'd1);
        check("scalar.operand_ready_low", 32'(operand_ready), 32'd0);
        scalar_valid = 1'b1; scalar_value = 32'hFFFF_FFF9;
        tick(1);
        scalar_valid = 1'b0;
        check("scalar.start", 32'(calc_start), 32'd1);
        check("scalar.value", scalar_o, 32'hFFFF_FFF9);
        check("scalar.op_b_zero", 32'(op_b_id), 32'd0);
        calc_done = 1'b1; calc_err = 1'b1;
        tick(1);
        check("scalar.done_in_start_ignored", 32'(busy) << 1 | 32'(error), 32'd2);
        tick(1);
        calc_done = 1'b0; calc_err = 1'b0;
        check("scalar.error", 32'(error), 32'd1);
        check("scalar.done", 32'(done), 32'd0);
        tick(1);
        check("scalar.idle", 32'(busy), 32'd0);
        check("scalar.starts", 32'(n_starts), 32'd3);

        // Inconsistent pair: double with transpose.
        op_mode = OP_DOUBLE; calc_type = CALC_TRANSPOSE; confirm = 1'b1;
        operand_valid = 1'b1; operand_id = 3'd6;
        tick(1);
        confirm = 1'b0;
        check("bad.no_ready", 32'(operand_ready), 32'd0);
        tick(1);
        operand_valid = 1'b0;
        check("bad.error", 32'(error), 32'd1);
        check("bad.done", 32'(done), 32'd0);
        tick(1);
        check("bad.idle", 32'(busy), 32'd0);
        check("bad.starts", 32'(n_starts), 32'd3);

        // Reset during GET_B; a second confirm before that must be ignored.
        op_mode = OP_DOUBLE; calc_type = CALC_ADD; confirm = 1'b1;
        operand_valid = 1'b1; operand_id = 3'd3;
        tick(1);
        confirm = 1'b0;
        tick(1);
        operand_valid = 1'b0;
        op_mode = OP_SINGLE; calc_type = CALC_TRANSPOSE; confirm = 1'b1;
        tick(1);
        confirm = 1'b0;
        check("midconfirm.calc_type", 32'(calc_type_o), 32'(CALC_ADD));
        check("midconfirm.ready_b", 32'(operand_ready), 32'd1);
        check("midconfirm.op_a", 32'(op_a_id), 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick(2);
        rst_n = 1'b1;
        operand_valid = 1'b1;
        tick(5);
        operand_valid = 1'b0;
        check_all_zero("after_reset");
        check("after_reset.starts", 32'(n_starts), 32'd3);

        // Watchdog behaviour.
        op_mode = OP_SINGLE; calc_type = CALC_TRANSPOSE; confirm = 1'b1;
        operand_valid = 1'b1; operand_id = 3'd2;
        tick(1);
        confirm = 1'b0;
        tick(1);
        operand_valid = 1'b0;
        check("wd.start", 32'(calc_start), 32'd1);
        tick(1);
`ifdef OP_DISPATCH_TIMEOUT_EN
        tick(15);
        check("wd.not_yet", 32'(error), 32'd0);
        check("wd.busy_wait", 32'(busy), 32'd1);
        tick(1);
        check("wd.error", 32'(error), 32'd1);
        check("wd.done", 32'(done), 32'd0);
        tick(1);
        check("wd.idle", 32'(busy), 32'd0);
`else
        tick(1000);
        check("wd.busy_held", 32'(busy), 32'd1);
        check("wd.no_error", 32'(error), 32'd0);
        calc_done = 1'b1;
        tick(1);
        calc_done = 1'b0;
        check("wd.late_done", 32'(done), 32'd1);
        tick(1);
        check("wd.idle", 32'(busy), 32'd0);
`endif
        check("final.starts", 32'(n_starts), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
